// File: rtl/pagerank_softreg_pkg.sv
// Address map and shared types for the PageRank SoftReg parameter bank.
package pagerank_softreg_pkg;
  localparam int DEFAULT_DATA_W = 64;

  localparam logic [31:0] N_VERT           = 32'h00;
  localparam logic [31:0] N_INEDGES        = 32'h08;
  localparam logic [31:0] VADDR            = 32'h10;
  localparam logic [31:0] IEADDR           = 32'h18;
  localparam logic [31:0] WRITE_ADDR0      = 32'h20;
  localparam logic [31:0] WRITE_ADDR1      = 32'h28;
  localparam logic [31:0] N_ROUNDS         = 32'h30;
  localparam logic [31:0] DONE_READ_PARAMS = 32'h38;
  localparam logic [31:0] DONE_ALL         = 32'h40;

  typedef enum logic [1:0] {PARAM, RESULT, SKID} resp_sel_t;
  typedef enum logic {IDLE, BUSY} ctrl_state_t;
endpackage

// File: rtl/softreg_param_bank.sv
// SoftReg responder: kernel parameter registers, start/done handshake and
// read responses, including a DONE_ALL read deferred until the kernel finishes.
module softreg_param_bank
  import pagerank_softreg_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              softreg_req_valid,
  input  logic              softreg_req_isWrite,
  input  logic [ADDR_W-1:0] softreg_req_addr,
  input  logic [DATA_W-1:0] softreg_req_data,
  output logic              softreg_resp_valid,
  output logic [DATA_W-1:0] softreg_resp_data,
  output logic [DATA_W-1:0] n_vert,
  output logic [DATA_W-1:0] n_inedges,
  output logic [DATA_W-1:0] vaddr,
  output logic [DATA_W-1:0] ieaddr,
  output logic [DATA_W-1:0] write_addr0,
  output logic [DATA_W-1:0] write_addr1,
  output logic [DATA_W-1:0] n_rounds,
  output logic              start,
  output logic              busy,
  input  logic              kernel_done,
  input  logic [DATA_W-1:0] kernel_result,
  output logic              param_err
);

  ctrl_state_t       state;
  logic              pending, done_latched, skid_vld_p1;
  logic [DATA_W-1:0] result_q, skid_data_p1;
  logic              rd, wr, kdone, da_rd, da_now, da_defer, da_drop, is_drp;
  logic              is_param, rd_vld_p0;
  logic [DATA_W-1:0] rd_data_p0;
  resp_sel_t         sel;

  assign busy     = (state == BUSY);
  assign rd       = softreg_req_valid && !softreg_req_isWrite;
  assign wr       = softreg_req_valid &&  softreg_req_isWrite;
  assign kdone    = kernel_done && busy;
  assign is_drp   = (softreg_req_addr == ADDR_W'(DONE_READ_PARAMS));
  assign da_rd    = rd && (softreg_req_addr == ADDR_W'(DONE_ALL));
  assign da_drop  = da_rd && pending;
  assign da_now   = da_rd && !pending && (done_latched || kdone);
  assign da_defer = da_rd && !pending && !done_latched && !kdone;
  assign rd_vld_p0 = rd && (!da_rd || da_now);

  // Read decode for the request presented this cycle
  always_comb begin
    is_param   = 1'b1;
    rd_data_p0 = '0;
    case (softreg_req_addr)
      ADDR_W'(N_VERT):      rd_data_p0 = n_vert;
      ADDR_W'(N_INEDGES):   rd_data_p0 = n_inedges;
      ADDR_W'(VADDR):       rd_data_p0 = vaddr;
      ADDR_W'(IEADDR):      rd_data_p0 = ieaddr;
      ADDR_W'(WRITE_ADDR0): rd_data_p0 = write_addr0;
      ADDR_W'(WRITE_ADDR1): rd_data_p0 = write_addr1;
      ADDR_W'(N_ROUNDS):    rd_data_p0 = n_rounds;
      ADDR_W'(DONE_READ_PARAMS): begin
        is_param   = 1'b0;
        rd_data_p0 = {{(DATA_W-1){1'b0}}, busy};
      end
      ADDR_W'(DONE_ALL): begin
        is_param   = 1'b0;
        rd_data_p0 = done_latched ? result_q : kernel_result;
      end
      default: is_param = 1'b0;
    endcase
  end

  // The deferred DONE_ALL answer wins; a displaced read waits one cycle in the skid
  always_comb begin
    if (pending && kdone) sel = RESULT;
    else if (skid_vld_p1) sel = SKID;
    else                  sel = PARAM;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      pending            <= 1'b0;
      done_latched       <= 1'b0;
      result_q           <= '0;
      start              <= 1'b0;
      param_err          <= 1'b0;
      skid_vld_p1        <= 1'b0;
      skid_data_p1       <= '0;
      softreg_resp_valid <= 1'b0;
      softreg_resp_data  <= '0;
      n_vert             <= '0;
      n_inedges          <= '0;
      vaddr              <= '0;
      ieaddr             <= '0;
      write_addr0        <= '0;
      write_addr1        <= '0;
      n_rounds           <= '0;
    end else begin
      start <= 1'b0;

      if (wr && is_param) begin
        if (busy) begin
          param_err <= 1'b1;
        end else begin
          case (softreg_req_addr)
            ADDR_W'(N_VERT):      n_vert      <= softreg_req_data;
            ADDR_W'(N_INEDGES):   n_inedges   <= softreg_req_data;
            ADDR_W'(VADDR):       vaddr       <= softreg_req_data;
            ADDR_W'(IEADDR):      ieaddr      <= softreg_req_data;
            ADDR_W'(WRITE_ADDR0): write_addr0 <= softreg_req_data;
            ADDR_W'(WRITE_ADDR1): write_addr1 <= softreg_req_data;
            ADDR_W'(N_ROUNDS):    n_rounds    <= softreg_req_data;
            default: ;
          endcase
        end
      end

      if (wr && is_drp) begin
        if (busy) begin
          param_err <= 1'b1;
        end else begin
          start        <= 1'b1;
          state        <= BUSY;
          done_latched <= 1'b0;
        end
      end

      if (kdone) begin
        state        <= IDLE;
        done_latched <= 1'b1;
        result_q     <= kernel_result;
        pending      <= 1'b0;
      end

      if (da_defer) pending   <= 1'b1;
      if (da_drop)  param_err <= 1'b1;

      case (sel)
        RESULT: begin
          softreg_resp_valid <= 1'b1;
          softreg_resp_data  <= kernel_result;
          skid_vld_p1        <= rd_vld_p0;
          skid_data_p1       <= rd_data_p0;
        end
        SKID: begin
          softreg_resp_valid <= 1'b1;
          softreg_resp_data  <= skid_data_p1;
          skid_vld_p1        <= rd_vld_p0;
          skid_data_p1       <= rd_data_p0;
        end
        default: begin
          softreg_resp_valid <= rd_vld_p0;
          softreg_resp_data  <= rd_vld_p0 ? rd_data_p0 : '0;
          skid_vld_p1        <= 1'b0;
        end
      endcase
    end
  end

endmodule
